// File: rtl/button_led_debounce.sv
// Multi-channel button synchroniser/debouncer driving LEDs in DIRECT or TOGGLE mode.
// Optional press_pulse output is enabled by defining BUTTON_LED_PULSE_OUT_EN.
module button_led_debounce #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] push_button,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] led,
`ifdef BUTTON_LED_PULSE_OUT_EN
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] press_pulse
`else
    output logic [CHANNELS-1:0] btn_state
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] toggle_q;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= push_button;
            sync2 <= sync1;
        end
    end

    // Each channel counts consecutive cycles of disagreement; any agreement discards progress.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;

        assign accept[i] = (sync2[i] != stable[i]) && (cnt == CNT_MAX);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (sync2[i] == stable[i]) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = accept & ~stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= '0;
            toggle_q <= '0;
        end else begin
            stable   <= stable ^ accept;
            toggle_q <= toggle_q ^ (rise & mode);
        end
    end

    assign btn_state = stable;
    assign led       = (mode & toggle_q) | (~mode & stable);

`ifdef BUTTON_LED_PULSE_OUT_EN
    logic [CHANNELS-1:0] stable_d;

    // Pulse lands one cycle after btn_state rises, hence the extra delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d    <= '0;
            press_pulse <= '0;
        end else begin
            stable_d    <= stable;
            press_pulse <= stable & ~stable_d;
        end
    end
`endif

endmodule

// File: tb/tb_button_led_debounce.sv
// Self-checking bench for button_led_debounce: directed scenarios plus randomized traffic
// checked against a window-based reference model.
module tb_button_led_debounce;

    localparam int CH = 2;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] push_button;
    logic [CH-1:0] mode;
    logic [CH-1:0] led;
    logic [CH-1:0] btn_state;
`ifdef BUTTON_LED_PULSE_OUT_EN
    logic [CH-1:0] press_pulse;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_led_debounce #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_button(push_button),
        .mode       (mode),
        .led        (led),
`ifdef BUTTON_LED_PULSE_OUT_EN
        .btn_state  (btn_state),
        .press_pulse(press_pulse)
`else
        .btn_state  (btn_state)
`endif
    );

    // Reference model: a level is accepted once the last DB synchronised samples all
    // disagree with the currently accepted level.
    logic [CH-1:0] m_d1, m_d2, m_stable, m_toggle, m_rise_q, m_pulse, m_next, m_rise;
    logic [DB-1:0] m_hist [CH];

    always @(posedge clk) begin
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_toggle = '0;
            m_rise_q = '0; m_pulse = '0;
            for (int c = 0; c < CH; c++) m_hist[c] = '0;
        end else begin
            m_next = m_stable;
            for (int c = 0; c < CH; c++) begin
                m_hist[c] = {m_hist[c][DB-2:0], m_d2[c]};
                if (m_hist[c] == {DB{~m_stable[c]}}) m_next[c] = ~m_stable[c];
            end
            m_rise   = m_next & ~m_stable;
            m_toggle = m_toggle ^ (m_rise & mode);
            m_pulse  = m_rise_q;
            m_rise_q = m_rise;
            m_stable = m_next;
            m_d2     = m_d1;
            m_d1     = push_button;
        end
    end

    task automatic checkValue(input string tag, input logic [CH-1:0] observed, input logic [CH-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("btn_state", btn_state, m_stable);
        checkValue("led", led, (mode & m_toggle) | (~mode & m_stable));
`ifdef BUTTON_LED_PULSE_OUT_EN
        checkValue("press_pulse", press_pulse, m_pulse);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [CH-1:0] pb, input logic [CH-1:0] md, input int n);
        push_button = pb;
        mode        = md;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; push_button = 2'b11; mode = 2'b00;

        // Reset held with both buttons pressed, then accepted on the 6th edge after release.
        $display("[TB] reset");
        repeat (3) begin
            tick();
            checkValue("rst_led", led, 2'b00);
            checkValue("rst_btn", btn_state, 2'b00);
        end
        rst = 1'b0;
        repeat (5) tick();
        checkValue("rst_btn_e5", btn_state, 2'b00);
        tick();
        checkValue("rst_btn_e6", btn_state, 2'b11);
        applyStimulus(2'b00, 2'b00, 8);

        $display("[TB] direct");
        applyStimulus(2'b01, 2'b00, 5);
        checkValue("dir_rise_e5", led, 2'b00);
        tick();
        checkValue("dir_rise_e6", led, 2'b01);
        repeat (14) tick();
        applyStimulus(2'b00, 2'b00, 5);
        checkValue("dir_fall_e5", led, 2'b01);
        tick();
        checkValue("dir_fall_e6", led, 2'b00);
        repeat (4) tick();

        $display("[TB] bounce");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, 2'b00, 3);
            applyStimulus(2'b00, 2'b00, 3);
        end
        checkValue("bounce_btn", btn_state, 2'b00);
        checkValue("bounce_led", led, 2'b00);
        repeat (6) tick();

        $display("[TB] toggle");
        applyStimulus(2'b10, 2'b10, 6);
        checkValue("tog_first", led, 2'b10);
        applyStimulus(2'b10, 2'b10, 4);
        applyStimulus(2'b00, 2'b10, 10);
        checkValue("tog_hold", led, 2'b10);
        applyStimulus(2'b10, 2'b10, 6);
        checkValue("tog_second", led, 2'b00);
        applyStimulus(2'b10, 2'b10, 4);
        applyStimulus(2'b00, 2'b10, 10);

        $display("[TB] simultaneous + mode switch");
        applyStimulus(2'b11, 2'b01, 5);
        checkValue("sim_e5", led, 2'b00);
        tick();
        checkValue("sim_e6", led, 2'b11);
        mode = 2'b10;
        #1;
        checkOutput();
        checkValue("mode_switch", led, 2'b01);
        applyStimulus(2'b11, 2'b10, 4);
        applyStimulus(2'b00, 2'b00, 10);

        $display("[TB] single press for pulse");
        applyStimulus(2'b01, 2'b00, 6);
        checkValue("pulse_btn", btn_state, 2'b01);
`ifdef BUTTON_LED_PULSE_OUT_EN
        checkValue("pulse_e6", press_pulse, 2'b00);
        tick();
        checkValue("pulse_e7", press_pulse, 2'b01);
        tick();
        checkValue("pulse_e8", press_pulse, 2'b00);
        applyStimulus(2'b01, 2'b00, 2);
`else
        applyStimulus(2'b01, 2'b00, 4);
`endif
        applyStimulus(2'b00, 2'b00, 10);

        $display("[TB] random");
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                applyStimulus(CH'($urandom), mode, $urandom_range(1, 3));
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) mode = CH'($urandom);
            applyStimulus(CH'($urandom), mode, $urandom_range(1, 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
